// File: rtl/pwm_pkg.sv
// Shared servo-PWM constants and FSM state type, used by the decoder and the PWM generator.
package pwm_pkg;

  localparam int unsigned DEF_PERIOD_CYCLES  = 1_000_000;
  localparam int unsigned DEF_MIN_PULSE      = 25_000;
  localparam int unsigned DEF_MAX_PULSE      = 125_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 2_000_000;
  localparam int unsigned DUTY_MAX           = 125;
  localparam int unsigned DUTY_DEFAULT       = 25;
  localparam int unsigned WIDTH_W            = 20;
  localparam int unsigned DUTY_W             = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM line plus rise/fall detection
// against a third registered copy.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/pwm_decoder.sv
// Servo PWM decoder: measures the synchronized high time and converts it to a 0..125 duty
// with a prescaled accumulator, flagging short/long pulses and loss of signal.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned MIN_PULSE      = DEF_MIN_PULSE,
  parameter int unsigned MAX_PULSE      = DEF_MAX_PULSE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               pwm_in,
  output logic [DUTY_W-1:0]  duty,
  output logic [WIDTH_W-1:0] pulse_width,
  output logic               valid,
  output logic               err_short,
  output logic               err_long,
  output logic               lost
);

  localparam int unsigned STEP  = (MAX_PULSE - MIN_PULSE) / DUTY_MAX;
  localparam int unsigned PRE_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WIDTH_W-1:0] MinWidth    = WIDTH_W'(MIN_PULSE);
  localparam logic [WIDTH_W-1:0] MaxWidth    = WIDTH_W'(MAX_PULSE);
  localparam logic [PRE_W-1:0]   StepLast    = PRE_W'(STEP - 1);
  localparam logic [GAP_W-1:0]   GapMax      = GAP_W'(TIMEOUT_CYCLES);
  localparam logic [DUTY_W-1:0]  DutyMax     = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0]  DutyDefault = DUTY_W'(DUTY_DEFAULT);

  if (MIN_PULSE >= MAX_PULSE || MAX_PULSE >= PERIOD_CYCLES || STEP == 0) begin : g_param_check
    $error("pwm_decoder: inconsistent pulse parameters");
  end

  logic w_rise;
  logic w_fall;

  pwm_sync_edge u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async (pwm_in),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  pwm_state_e         r_state, w_state_d;
  logic [WIDTH_W-1:0] r_width, w_width_d, w_width_inc;
  logic [PRE_W-1:0]   r_pre, w_pre_d;
  logic [DUTY_W-1:0]  r_acc, w_acc_d;
  logic [GAP_W-1:0]   r_gap, w_gap_d, w_gap_inc;
  logic               r_lost, w_lost_d;
  logic [DUTY_W-1:0]  r_duty, w_duty_d;
  logic [WIDTH_W-1:0] r_pw, w_pw_d;
  logic               r_valid, w_valid_d;
  logic               r_short, w_short_d;
  logic               r_long, w_long_d;

  always_comb begin
    w_state_d   = r_state;
    w_width_d   = r_width;
    w_pre_d     = r_pre;
    w_acc_d     = r_acc;
    w_gap_d     = r_gap;
    w_lost_d    = r_lost;
    w_duty_d    = r_duty;
    w_pw_d      = r_pw;
    w_valid_d   = 1'b0;
    w_short_d   = 1'b0;
    w_long_d    = 1'b0;
    w_width_inc = (r_width == '1) ? r_width : r_width + WIDTH_W'(1);
    w_gap_inc   = (r_gap == GapMax) ? r_gap : r_gap + GAP_W'(1);

    if (!en) begin
      w_state_d = StIdle;
      w_width_d = '0;
      w_pre_d   = '0;
      w_acc_d   = '0;
      w_gap_d   = '0;
      w_lost_d  = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StLow: begin
          // A rise beats a simultaneous timeout, so lost never sets in that cycle.
          if (w_rise) begin
            w_state_d = StHigh;
            w_width_d = '0;
            w_pre_d   = '0;
            w_acc_d   = '0;
            w_gap_d   = '0;
            w_lost_d  = 1'b0;
          end else begin
            w_gap_d = w_gap_inc;
            if (w_gap_inc == GapMax) w_lost_d = 1'b1;
          end
        end
        StHigh: begin
          w_width_d = w_width_inc;
          // Each cycle past MIN_PULSE advances the prescaler; every STEP of them is one duty unit.
          if (w_width_inc > MinWidth) begin
            if (r_pre == StepLast) begin
              w_pre_d = '0;
              if (r_acc < DutyMax) w_acc_d = r_acc + DUTY_W'(1);
            end else begin
              w_pre_d = r_pre + PRE_W'(1);
            end
          end
          if (w_fall) begin
            w_state_d = StLow;
            w_pw_d    = w_width_inc;
            if (w_width_inc < MinWidth) begin
              w_short_d = 1'b1;
            end else if (w_width_inc > MaxWidth) begin
              w_long_d = 1'b1;
            end else begin
              w_valid_d = 1'b1;
              w_duty_d  = w_acc_d;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_width <= '0;
      r_pre   <= '0;
      r_acc   <= '0;
      r_gap   <= '0;
      r_lost  <= 1'b0;
      r_duty  <= DutyDefault;
      r_pw    <= '0;
      r_valid <= 1'b0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_width <= w_width_d;
      r_pre   <= w_pre_d;
      r_acc   <= w_acc_d;
      r_gap   <= w_gap_d;
      r_lost  <= w_lost_d;
      r_duty  <= w_duty_d;
      r_pw    <= w_pw_d;
      r_valid <= w_valid_d;
      r_short <= w_short_d;
      r_long  <= w_long_d;
    end
  end

  assign duty        = r_duty;
  assign pulse_width = r_pw;
  assign valid       = r_valid;
  assign err_short   = r_short;
  assign err_long    = r_long;
  assign lost        = r_lost;

endmodule
